// File: rtl/cond_add.sv
// Double-dabble digit adjuster: a BCD digit of 5 or more gets +3 so the
// following left shift carries correctly into the next decade.
module cond_add (
  input  logic [3:0] d,
  output logic [3:0] q
);

  assign q = (d >= 4'd5) ? d + 4'd3 : d;

endmodule

// File: rtl/bin2bcd_seq.sv
// Sequential binary-to-BCD converter (shift-and-add-3), one input bit per clock.
// Results are registered and change only when a conversion completes.
module bin2bcd_seq #(
  parameter int WIDTH  = 16,
  parameter int DIGITS = 5
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [WIDTH-1:0]      bin,
  output logic                  busy,
  output logic                  done,
  output logic [4*DIGITS-1:0]   bcd,
  output logic                  overflow
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_CONV = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]              state, state_nx;
  logic [WIDTH-1:0]        sr;
  logic [DIGITS-1:0][3:0]  scr, adj;
  logic                    ovf_st;
  logic [CW-1:0]           cnt;
  logic [4*DIGITS:0]       shifted;

  for (genvar g = 0; g < DIGITS; g++) begin : g_dig
    cond_add u_ca (.d(scr[g]), .q(adj[g]));
  end

  // Top bit is what falls out of the last digit; bottom bit is the next input bit.
  assign shifted = {adj, sr[WIDTH-1]};

  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:  if (start) state_nx = S_CONV;
      S_CONV:  if (cnt == '0) state_nx = S_DONE;
      S_DONE:  state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      sr       <= '0;
      scr      <= '0;
      ovf_st   <= 1'b0;
      cnt      <= '0;
      bcd      <= '0;
      overflow <= 1'b0;
    end else begin
      state <= state_nx;
      case (state)
        S_IDLE: if (start) begin
          sr     <= bin;
          scr    <= '0;
          ovf_st <= 1'b0;
          cnt    <= CW'(WIDTH - 1);
        end
        S_CONV: begin
          scr    <= shifted[4*DIGITS-1:0];
          sr     <= sr << 1;
          ovf_st <= ovf_st | shifted[4*DIGITS];
          if (cnt == '0) begin
            // Publish the digits produced by this final shift, not the stale scratch.
            bcd      <= shifted[4*DIGITS-1:0];
            overflow <= ovf_st | shifted[4*DIGITS];
          end else begin
            cnt <= cnt - CW'(1);
          end
        end
        default: ;
      endcase
    end
  end

  assign busy = (state != S_IDLE);
  assign done = (state == S_DONE);

endmodule
